// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the CPU/DMA data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W = 16;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        CPU_LAST,
        DMA_LAST,
        DMA_BURST
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Round-robin owner FSM with a bounded DMA burst lock; grants are combinational.
// Latency 0 (grant in the request cycle); a losing requester stalls with req held.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic c_req,
    input  logic d_req,
    input  logic d_lock,
    output logic c_gnt,
    output logic d_gnt
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    arb_state_t state, state_nxt;
    logic [7:0] burst_cnt, burst_nxt;
    logic       pick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= DMA_LAST;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        pick      = OWN_C;
        state_nxt = state;
        burst_nxt = burst_cnt;

        case (state)
            CPU_LAST:  pick = OWN_D;
            DMA_LAST:  pick = OWN_C;
            DMA_BURST: pick = (burst_cnt < MAX_CNT) ? OWN_D : OWN_C;
            default:   pick = OWN_C;
        endcase

        // Gating with reset_n kills any beat the instant reset asserts.
        c_gnt = reset_n & c_req & (~d_req | (pick == OWN_C));
        d_gnt = reset_n & d_req & (~c_req | (pick == OWN_D));

        if (c_gnt) begin
            state_nxt = CPU_LAST;
            burst_nxt = 8'd0;
        end else if (d_gnt && d_lock) begin
            state_nxt = DMA_BURST;
            if (state != DMA_BURST)
                burst_nxt = 8'd1;
            else if (burst_cnt < MAX_CNT)
                burst_nxt = burst_cnt + 8'd1;
        end else if (d_gnt) begin
            state_nxt = DMA_LAST;
            burst_nxt = 8'd0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between CPU (C) and DMA (D); DMEM_ARB_PERF_EN adds stall counters.
// Grant same cycle, read data one cycle later; the loser stalls holding its request.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_req,
    input  logic              d_req,
    input  logic              c_we,
    input  logic              d_we,
    input  logic [DATA_W-1:0] c_addr,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              c_gnt,
    output logic              d_gnt,
    output logic              c_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              c_stall,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       c_stall_cnt,
    output logic [15:0]       d_stall_cnt
`endif
);

    dmem_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .c_req   (c_req),
        .d_req   (d_req),
        .d_lock  (d_lock),
        .c_gnt   (c_gnt),
        .d_gnt   (d_gnt)
    );

    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_we    = c_we;
            mem_rd    = ~c_we;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
            mem_rd    = ~d_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~d_we;
            if (c_gnt && !c_we)
                c_rdata <= mem_rdata;
            if (d_gnt && !d_we)
                d_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_stall_cnt <= 16'd0;
            d_stall_cnt <= 16'd0;
        end else begin
            if (c_stall && c_stall_cnt != 16'hFFFF)
                c_stall_cnt <= c_stall_cnt + 16'd1;
            if (d_req && !d_gnt && d_stall_cnt != 16'hFFFF)
                d_stall_cnt <= d_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter with a fairness/burst reference model.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, d_req, c_we, d_we, d_lock;
    logic [15:0] c_addr, d_addr, c_wdata, d_wdata;
    logic        c_gnt, d_gnt, c_rvalid, d_rvalid, c_stall;
    logic [15:0] c_rdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_rd;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] c_stall_cnt, d_stall_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .c_req     (c_req),
        .d_req     (d_req),
        .c_we      (c_we),
        .d_we      (d_we),
        .c_addr    (c_addr),
        .d_addr    (d_addr),
        .c_wdata   (c_wdata),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .c_gnt     (c_gnt),
        .d_gnt     (d_gnt),
        .c_rvalid  (c_rvalid),
        .d_rvalid  (d_rvalid),
        .c_rdata   (c_rdata),
        .d_rdata   (d_rdata),
        .c_stall   (c_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .c_stall_cnt (c_stall_cnt),
        .d_stall_cnt (d_stall_cnt)
`endif
    );

    function automatic logic [15:0] init_val(int a);
        return (a == 16) ? 16'hBEEF : (16'(a * 257) ^ 16'h5A5A);
    endfunction

    // Memory seen by the DUT: 256 words, aliased on the low address byte.
    logic [15:0] phys [0:255];
    logic        mem_ready = 1'b0;
    assign mem_rdata = phys[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) phys[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            phys[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // Reference model state.
    logic [15:0] ref_mem [0:255];
    bit          last_d, locked;
    int          run;
    bit          ex_crv, ex_drv;
    logic [15:0] ex_crd, ex_drd;
    int          ex_cs, ex_ds;
    bit          obs_cg, obs_dg, obs_crv, obs_drv, obs_cst;
    logic [15:0] obs_crd, obs_drd;

    int total  = 0;
    int passed = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        last_d = 1'b1;
        locked = 1'b0;
        run    = 0;
        ex_crv = 1'b0;
        ex_drv = 1'b0;
        ex_crd = 16'h0;
        ex_drd = 16'h0;
        ex_cs  = 0;
        ex_ds  = 0;
    endtask

    // DMA wins a contest if the CPU went last, or DMA holds an unexhausted lock.
    function automatic bit dma_wins();
        if (!last_d) return 1'b1;
        return locked && (run < MAX_BURST);
    endfunction

    // One clock with inputs already driven: check at negedge, advance model at posedge.
    task automatic cycle();
        bit          eg_c, eg_d;
        logic [15:0] e_addr, e_wd;
        bit          e_we, e_rd;
        @(negedge clk);
        eg_c   = c_req && (!d_req || !dma_wins());
        eg_d   = d_req && (!c_req ||  dma_wins());
        e_addr = eg_c ? c_addr : (eg_d ? d_addr : 16'h0);
        e_wd   = eg_c ? c_wdata : (eg_d ? d_wdata : 16'h0);
        e_we   = (eg_c && c_we) || (eg_d && d_we);
        e_rd   = (eg_c && !c_we) || (eg_d && !d_we);
        obs_cg = c_gnt;  obs_dg = d_gnt;  obs_cst = c_stall;
        obs_crv = c_rvalid; obs_drv = d_rvalid;
        obs_crd = c_rdata;  obs_drd = d_rdata;
        check("c_gnt", c_gnt, eg_c);
        check("d_gnt", d_gnt, eg_d);
        check("c_stall", c_stall, c_req && !eg_c);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        check("mem_we", mem_we, e_we);
        check("mem_rd", mem_rd, e_rd);
        check("c_rvalid", c_rvalid, ex_crv);
        check("d_rvalid", d_rvalid, ex_drv);
        check("c_rdata", c_rdata, ex_crd);
        check("d_rdata", d_rdata, ex_drd);
`ifdef DMEM_ARB_PERF_EN
        check("c_stall_cnt", c_stall_cnt, ex_cs);
        check("d_stall_cnt", d_stall_cnt, ex_ds);
`endif
        @(posedge clk);
        ex_crv = eg_c && !c_we;
        ex_drv = eg_d && !d_we;
        if (ex_crv) ex_crd = ref_mem[c_addr[7:0]];
        if (ex_drv) ex_drd = ref_mem[d_addr[7:0]];
        if (eg_c && c_we) ref_mem[c_addr[7:0]] = c_wdata;
        if (eg_d && d_we) ref_mem[d_addr[7:0]] = d_wdata;
        if (c_req && !eg_c && ex_cs < 65535) ex_cs++;
        if (d_req && !eg_d && ex_ds < 65535) ex_ds++;
        if (eg_c) begin
            last_d = 1'b0; locked = 1'b0; run = 0;
        end else if (eg_d && d_lock) begin
            run    = locked ? ((run < MAX_BURST) ? run + 1 : run) : 1;
            locked = 1'b1;
            last_d = 1'b1;
        end else if (eg_d) begin
            last_d = 1'b1; locked = 1'b0; run = 0;
        end
        #1;
    endtask

    task automatic c_only(logic we, logic [15:0] a, logic [15:0] wd);
        c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd; d_req = 1'b0;
    endtask

    initial begin
        logic [5:0]  v2, s2;
        logic [9:0]  v3;
        int          c0, d0;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        reset_n = 1'b0;
        c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0; d_lock = 1'b0;
        c_addr = 16'h0; d_addr = 16'h0; c_wdata = 16'h0; d_wdata = 16'h0;
        model_reset();
        @(posedge clk); #1;

        // Reset with both requesting: nothing may reach memory.
        c_req = 1'b1; d_req = 1'b1; c_addr = 16'h0010; d_addr = 16'h0044;
        @(negedge clk);
        check("rst_c_gnt", c_gnt, 1'b0);
        check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_c_rvalid", c_rvalid, 1'b0);
        check("rst_d_rvalid", d_rvalid, 1'b0);
        check("rst_c_rdata", c_rdata, 16'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        c_only(1'b0, 16'h0010, 16'h0);
        cycle();
        check("t1_c_gnt", obs_cg, 1'b1);
        c_req = 1'b0;
        cycle();
        check("t1_c_rvalid", obs_crv, 1'b1);
        check("t1_c_rdata", obs_crd, 16'hBEEF);

        // Alternation from DMA_LAST.
        d_req = 1'b1; d_lock = 1'b0; d_we = 1'b0; d_addr = 16'h0031;
        cycle();
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0032;
        for (int i = 0; i < 6; i++) begin
            cycle();
            v2[i] = obs_dg;
            s2[i] = obs_cst;
        end
        check("t2_gnt_seq", v2, 6'b101010);
        check("t2_stall_seq", s2, 6'b101010);

        // Locked burst from CPU_LAST: 8 D, 1 C, then D again.
        c_only(1'b0, 16'h0033, 16'h0);
        cycle();
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        for (int i = 0; i < 10; i++) begin
            cycle();
            v3[i] = obs_dg;
        end
        check("t3_burst_seq", v3, 10'b10_1111_1111);

        // DMA write then CPU read-back.
        c_req = 1'b0; d_req = 1'b1; d_lock = 1'b0; d_we = 1'b1;
        d_addr = 16'h0020; d_wdata = 16'h1234;
        cycle();
        c_only(1'b0, 16'h0020, 16'h0);
        cycle();
        check("t4_c_gnt", obs_cg, 1'b1);
        c_req = 1'b0;
        cycle();
        check("t4_c_rvalid", obs_crv, 1'b1);
        check("t4_c_rdata", obs_crd, 16'h1234);

        // Reset during the fourth burst beat.
        c_only(1'b0, 16'h0050, 16'h0);
        cycle();
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 16'h0051;
        for (int i = 0; i < 3; i++) cycle();
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_d_gnt", d_gnt, 1'b0);
        check("t5_c_gnt", c_gnt, 1'b0);
        check("t5_mem_rd", mem_rd, 1'b0);
        check("t5_d_rvalid", d_rvalid, 1'b0);
        check("t5_d_rdata", d_rdata, 16'h0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1; d_lock = 1'b0;
        cycle();
        check("t5_first_c", obs_cg, 1'b1);

`ifdef DMEM_ARB_PERF_EN
        c0 = c_stall_cnt;
        d0 = d_stall_cnt;
        for (int i = 0; i < 10; i++) cycle();
        check("t6_c_stall_cnt", c_stall_cnt - 16'(c0), 16'd5);
        check("t6_d_stall_cnt", d_stall_cnt - 16'(d0), 16'd5);
`else
        c0 = 0;
        d0 = 0;
`endif

        // Random traffic; a request and its payload are held until granted.
        for (int n = 0; n < 400; n++) begin
            if (!c_req || obs_cg) begin
                c_req   = ($urandom_range(0, 2) != 0);
                c_we    = $urandom_range(0, 1) == 1;
                c_addr  = 16'($urandom);
                c_wdata = 16'($urandom);
            end
            if (!d_req || obs_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_lock  = ($urandom_range(0, 3) != 0);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
